// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the PLL / clkout-domain logic.
// The sequencer takes the master side; the PLL and its consumers take the slave side.
interface pll_lock_sequencer_if;
    logic       pll_lock_in;
    logic       restart_req;
    logic       pll_reset;
    logic       downstream_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        input  pll_lock_in,
        input  restart_req,
        output pll_reset,
        output downstream_reset,
        output ready,
        output fail,
        output retry_count,
        output lock_loss_count
    );

    modport slave (
        output pll_lock_in,
        output restart_req,
        input  pll_reset,
        input  downstream_reset,
        input  ready,
        input  fail,
        input  retry_count,
        input  lock_loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock sequencer on the free-running board clock.
// Pulses the PLL reset, waits for lock, requires lock to stay stable before
// releasing the downstream reset, retries on timeout and latches a fail state
// after too many timeouts. Loss of lock while running re-asserts the
// downstream reset immediately and re-acquires.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 32,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_lock_sequencer_if.master seq
);

    localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    // The counter only ever reaches MAX_CNT-1 before a state change clears it.
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             lock_sync_p0;
    logic             lock_sync_p1;
    logic             lock_s;

    logic             cnt_clr;
    logic             retry_inc;
    logic             retry_clr;
    logic             loss_inc;

    logic             pll_reset_d;
    logic             downstream_reset_d;
    logic             ready_d;
    logic             fail_d;

    logic             pll_reset_q;
    logic             downstream_reset_q;
    logic             ready_q;
    logic             fail_q;
    logic [3:0]       retry_count_q;
    logic [7:0]       lock_loss_count_q;

    assign lock_s = lock_sync_p1;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
        end else begin
            lock_sync_p0 <= seq.pll_lock_in;
            lock_sync_p1 <= lock_sync_p0;
        end
    end

    // Next-state logic; restart outranks lock loss and timeout.
    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        loss_inc   = 1'b0;
        cnt_clr    = 1'b0;
        if (seq.restart_req) begin
            next_state = ST_RESET_PLL;
            cnt_clr    = 1'b1;
            retry_clr  = 1'b1;
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        next_state = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins.
                    if (lock_s) begin
                        next_state = ST_STABILIZE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry_count_q == 4'(MAX_RETRIES)) begin
                            next_state = ST_FAIL;
                        end else begin
                            retry_inc  = 1'b1;
                            next_state = ST_RESET_PLL;
                        end
                    end
                end
                ST_STABILIZE: begin
                    // A dropout here is not a retry; the lock timeout simply restarts.
                    if (!lock_s) begin
                        next_state = ST_WAIT_LOCK;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        next_state = ST_RESET_PLL;
                        loss_inc   = 1'b1;
                        retry_clr  = 1'b1;
                    end
                end
                ST_FAIL: begin
                    next_state = ST_FAIL;
                end
                default: begin
                    next_state = ST_RESET_PLL;
                end
            endcase
        end
    end

    // Moore output decode of the upcoming state, registered below so outputs are glitch-free.
    always_comb begin
        pll_reset_d        = (next_state == ST_RESET_PLL);
        downstream_reset_d = (next_state != ST_RUN);
        ready_d            = (next_state == ST_RUN);
        fail_d             = (next_state == ST_FAIL);
    end

    // State and output registers; the resets assert asynchronously and release on clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_RESET_PLL;
            pll_reset_q        <= 1'b1;
            downstream_reset_q <= 1'b1;
            ready_q            <= 1'b0;
            fail_q             <= 1'b0;
        end else begin
            state              <= next_state;
            pll_reset_q        <= pll_reset_d;
            downstream_reset_q <= downstream_reset_d;
            ready_q            <= ready_d;
            fail_q             <= fail_d;
        end
    end

    // Shared phase timer plus the retry and saturating lock-loss counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt               <= '0;
            retry_count_q     <= '0;
            lock_loss_count_q <= '0;
        end else begin
            if (cnt_clr || (next_state != state)) begin
                cnt <= '0;
            end else if ((state == ST_RESET_PLL) || (state == ST_WAIT_LOCK) ||
                         (state == ST_STABILIZE)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (retry_clr) begin
                retry_count_q <= '0;
            end else if (retry_inc) begin
                retry_count_q <= retry_count_q + 4'd1;
            end

            if (loss_inc && (lock_loss_count_q != 8'hFF)) begin
                lock_loss_count_q <= lock_loss_count_q + 8'd1;
            end
        end
    end

    assign seq.pll_reset        = pll_reset_q;
    assign seq.downstream_reset = downstream_reset_q;
    assign seq.ready            = ready_q;
    assign seq.fail             = fail_q;
    assign seq.retry_count      = retry_count_q;
    assign seq.lock_loss_count  = lock_loss_count_q;

endmodule
